// File: rtl/compare_run_detector_pkg.sv
// Shared definitions for the compare/run detector: verdict encodings,
// run-tracking FSM states and the saturating increment helper.
package compare_run_detector_pkg;

  localparam logic [1:0] VERDICT_NONE = 2'b00;
  localparam logic [1:0] VERDICT_AGT  = 2'b01;
  localparam logic [1:0] VERDICT_BGT  = 2'b10;
  localparam logic [1:0] VERDICT_EQ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_A  = 2'd1,
    ST_RUN_B  = 2'd2,
    ST_RUN_EQ = 2'd3
  } run_state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/compare_run_detector_magnitude_compare_core.sv
// Combinational unsigned magnitude comparator with one-hot result.
module magnitude_compare_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_greater,
  output logic             equal,
  output logic             b_greater
);

  // Full-width unsigned comparison; exactly one output is high.
  always_comb begin
    a_greater = (a > b);
    equal     = (a == b);
    b_greater = (a < b);
  end

endmodule

// File: rtl/compare_run_detector.sv
// Two-stage streaming classifier: S1 captures operand pairs, S2 holds the
// verdict plus the length of the current run of identical verdicts.
module compare_run_detector
  import compare_run_detector_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       verdict,
  output logic [CNT_W-1:0] run_count,
  output logic             streak_hit
);

  localparam logic [31:0]      CNT_MAX   = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [WIDTH-1:0] r_a_p0;
  logic [WIDTH-1:0] r_b_p0;
  logic             r_vld_p0;

  logic             r_vld_p1;
  logic [1:0]       r_verdict_p1;
  logic [CNT_W-1:0] r_count_p1;
  logic             r_hit_p1;

  run_state_t       r_state;
  run_state_t       w_next_state;
  run_state_t       w_class_state;
  logic [1:0]       w_class_verdict;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_next_count;
  logic             w_next_hit;
  logic             w_advance;
  logic             w_load;
  logic             w_a_gt;
  logic             w_eq;
  logic             w_b_gt;

  assign w_advance = !r_vld_p1 || out_ready;
  assign w_load    = w_advance && r_vld_p0;
  assign in_ready  = w_advance && !rst;

  magnitude_compare_core #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a         (r_a_p0),
    .b         (r_b_p0),
    .a_greater (w_a_gt),
    .equal     (w_eq),
    .b_greater (w_b_gt)
  );

  // Map the one-hot comparator result to a run class and its verdict code.
  always_comb begin
    w_class_state   = ST_RUN_EQ;
    w_class_verdict = VERDICT_EQ;
    if (w_a_gt) begin
      w_class_state   = ST_RUN_A;
      w_class_verdict = VERDICT_AGT;
    end else if (w_b_gt) begin
      w_class_state   = ST_RUN_B;
      w_class_verdict = VERDICT_BGT;
    end else if (!w_eq) begin
      w_class_state   = ST_RUN_EQ;
      w_class_verdict = VERDICT_EQ;
    end
  end

  assign w_inc = CNT_W'(sat_inc(32'(r_count_p1), CNT_MAX));

  // Run FSM next state: only a valid beat entering S2 extends or restarts a run.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count_p1;
    w_next_hit   = 1'b0;
    if (w_load) begin
      if (r_state == w_class_state) begin
        w_next_count = w_inc;
        // A saturated counter stays equal to itself, so it cannot re-fire.
        w_next_hit   = (w_inc == RUN_LEN_C) && (r_count_p1 != CNT_MAX_C);
      end else begin
        w_next_state = w_class_state;
        w_next_count = ONE_C;
        w_next_hit   = (RUN_LEN_C == ONE_C);
      end
    end
  end

  // Run FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // S1 capture: operands load on accept, a bubble is recorded otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
    end else if (w_advance) begin
      r_vld_p0 <= in_valid;
    end
    if (in_valid && in_ready) begin
      r_a_p0 <= a;
      r_b_p0 <= b;
    end
  end

  // ---- stage boundary S1 -> S2 ----
  // S2 output register: frozen under back-pressure, updated on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_verdict_p1 <= VERDICT_NONE;
      r_count_p1   <= '0;
      r_hit_p1     <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1 <= r_vld_p0;
      r_hit_p1 <= w_next_hit;
      if (r_vld_p0) begin
        r_verdict_p1 <= w_class_verdict;
        r_count_p1   <= w_next_count;
      end
    end
  end

  assign out_valid  = r_vld_p1;
  assign verdict    = r_verdict_p1;
  assign run_count  = r_count_p1;
  assign streak_hit = r_hit_p1;

endmodule
